// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: registered data/busy/done plus optional edge strobes.
// Define PULSE_GEN_EDGE_STROBE_EN to generate rise_strobe/fall_strobe; otherwise both are tied to 0.
module pulse_train_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] num_pulses,
    output logic             data,
    output logic             busy,
    output logic             done,
    output logic             rise_strobe,
    output logic             fall_strobe
);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] high_rld_q, high_rld_d;
    logic [CNT_W-1:0] low_rld_q, low_rld_d;
    logic             cont_q, cont_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Phase reload value: max(len,1)-1, so a zero length still lasts one cycle.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - One;
    endfunction

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pulse_d    = pulse_q;
        high_rld_d = high_rld_q;
        low_rld_d  = low_rld_q;
        cont_d     = cont_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !stop && !done_q) begin
                    state_d    = StHigh;
                    high_rld_d = reload(high_len);
                    low_rld_d  = reload(low_len);
                    cont_d     = (num_pulses == '0);
                    pulse_d    = num_pulses;
                    phase_d    = reload(high_len);
                end
            end
            StHigh: begin
                if (stop) begin
                    state_d = StIdle;
                    phase_d = '0;
                    pulse_d = '0;
                end else if (phase_q == '0) begin
                    state_d = StLow;
                    phase_d = low_rld_q;
                    if (!cont_q) begin
                        pulse_d = pulse_q - One;
                    end
                end else begin
                    phase_d = phase_q - One;
                end
            end
            StLow: begin
                if (stop) begin
                    state_d = StIdle;
                    phase_d = '0;
                    pulse_d = '0;
                end else if (phase_q == '0) begin
                    if (cont_q || (pulse_q != '0)) begin
                        state_d = StHigh;
                        phase_d = high_rld_q;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - One;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_d = (state_d == StHigh);
    assign busy_d = (state_d != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            pulse_q    <= '0;
            high_rld_q <= '0;
            low_rld_q  <= '0;
            cont_q     <= 1'b0;
            data_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pulse_q    <= pulse_d;
            high_rld_q <= high_rld_d;
            low_rld_q  <= low_rld_d;
            cont_q     <= cont_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef PULSE_GEN_EDGE_STROBE_EN
    logic rise_q, fall_q;

    // Same register stage as data_q, so strobes line up with the data edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= data_d & ~data_q;
            fall_q <= ~data_d & data_q;
        end
    end

    assign rise_strobe = rise_q;
    assign fall_strobe = fall_q;
`else
    assign rise_strobe = 1'b0;
    assign fall_strobe = 1'b0;
`endif

endmodule
